// File: rtl/expand_1s.sv
// expand_1s: stretches each run of 1s on a serial stream by EXT cycles, then forces GAP low cycles.
// Optional build macro EXPAND_RETRIG_EN: a 1 during the extension re-enters PASS and merges the runs.
module expand_1s #(
    parameter int EXT = 2,
    parameter int GAP = 1,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in,
    output logic          out,
    output logic          busy,
    output logic [CW-1:0] run_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PASS   = 2'd1,
        S_EXTEND = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // Counter preloads; guarded so a zero parameter never produces a negative value.
    localparam logic [CW-1:0] EXT_LOAD = (EXT > 0) ? CW'(EXT - 1) : '0;
    localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] run_cnt_nxt;
    logic          done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            run_cnt <= run_cnt_nxt;
        end
    end

    // 'done' marks the cycle an expansion finishes; the shared tail below counts it and picks GAP or IDLE.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        run_cnt_nxt = run_cnt;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (in) state_nxt = S_PASS;
            end
            S_PASS: begin
                if (!in) begin
                    if (EXT > 0) begin
                        state_nxt = S_EXTEND;
                        cnt_nxt   = EXT_LOAD;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            S_EXTEND: begin
`ifdef EXPAND_RETRIG_EN
                if (in) state_nxt = S_PASS;
                else
`endif
                if (cnt != '0) cnt_nxt = cnt - CW'(1);
                else done = 1'b1;
            end
            S_GAP: begin
                if (cnt != '0) cnt_nxt = cnt - CW'(1);
                else state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (done) begin
            run_cnt_nxt = run_cnt + CW'(1);
            if (GAP > 0) begin
                state_nxt = S_GAP;
                cnt_nxt   = GAP_LOAD;
            end else begin
                state_nxt = S_IDLE;
            end
        end
    end

    assign out  = (state == S_PASS) || (state == S_EXTEND);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_expand_1s.sv
// Self-checking bench for expand_1s: two instances (default and CW=4/EXT=0/GAP=0) against a run-length model.
// Honours EXPAND_RETRIG_EN when the build defines it.
module tb_expand_1s;

    localparam int A_EXT = 2, A_GAP = 1, A_CW = 8;
    localparam int B_EXT = 0, B_GAP = 0, B_CW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_a = 1'b0, in_b = 1'b0;
    logic            out_a, busy_a, out_b, busy_b;
    logic [A_CW-1:0] run_cnt_a;
    logic [B_CW-1:0] run_cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;

    expand_1s #(.EXT(A_EXT), .GAP(A_GAP), .CW(A_CW)) dut_a (
        .clk(clk), .reset(reset), .in(in_a), .out(out_a), .busy(busy_a), .run_cnt(run_cnt_a)
    );
    expand_1s #(.EXT(B_EXT), .GAP(B_GAP), .CW(B_CW)) dut_b (
        .clk(clk), .reset(reset), .in(in_b), .out(out_b), .busy(busy_b), .run_cnt(run_cnt_b)
    );

    always #5 clk = ~clk;

    // Model: hi = output pulse in progress, ext = input run already ended, rem = extra high cycles left,
    // g = edges still swallowed by the forced low gap, rc = completed expansions.
    typedef struct {
        bit hi;
        bit ext;
        int rem;
        int g;
        int rc;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, bit b, int ext_p, int gap_p, int cw);
        mdl_t n;
        bit   fin;
        n   = m;
        fin = 1'b0;
        if (m.g > 0) begin
            n.g = m.g - 1;
        end else if (!m.hi) begin
            if (b) begin
                n.hi  = 1'b1;
                n.ext = 1'b0;
                n.rem = ext_p;
            end
        end else if (!m.ext) begin
            if (b) n.rem = ext_p;
            else if (m.rem > 0) begin
                n.rem = m.rem - 1;
                n.ext = 1'b1;
            end else fin = 1'b1;
        end else begin
`ifdef EXPAND_RETRIG_EN
            if (b) begin
                n.ext = 1'b0;
                n.rem = ext_p;
            end else
`endif
            if (m.rem > 0) n.rem = m.rem - 1;
            else fin = 1'b1;
        end
        if (fin) begin
            n.hi  = 1'b0;
            n.ext = 1'b0;
            n.rc  = (m.rc + 1) % (1 << cw);
            n.g   = gap_p;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = step(ma, in_a, A_EXT, A_GAP, A_CW);
            mb = step(mb, in_b, B_EXT, B_GAP, B_CW);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic checkLiteral(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                                input logic [31:0] exp);
        checkOutput(name, dut_v, exp);
        checkOutput({name, ".model"}, mdl_v, exp);
    endtask

    task automatic applyStimulus(input bit a, input bit b);
        in_a = a;
        in_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        in_a  = 1'b0;
        in_b  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Every-cycle comparison of both instances against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("a.out", out_a, ma.hi);
            checkOutput("a.busy", busy_a, ma.hi || (ma.g > 0));
            checkOutput("a.run_cnt", run_cnt_a, ma.rc);
            checkOutput("b.out", out_b, mb.hi);
            checkOutput("b.busy", busy_b, mb.hi || (mb.g > 0));
            checkOutput("b.run_cnt", run_cnt_b, mb.rc);
        end
    end

    initial begin
        int s1_in[7]   = '{1, 1, 1, 0, 0, 0, 0};
        int s1_out[7]  = '{1, 1, 1, 1, 1, 0, 0};
        int s1_busy[7] = '{1, 1, 1, 1, 1, 1, 0};
        int s1_rc[7]   = '{0, 0, 0, 0, 0, 1, 1};
        int s2_in[5]   = '{1, 0, 0, 0, 0};
        int s2_out[5]  = '{1, 1, 1, 0, 0};
        int s3_in[8]   = '{1, 0, 1, 0, 0, 0, 0, 0};
`ifdef EXPAND_RETRIG_EN
        int s3_out[8]  = '{1, 1, 1, 1, 1, 0, 0, 0};
`else
        int s3_out[8]  = '{1, 1, 1, 0, 0, 0, 0, 0};
`endif
        int s4_in[13]  = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};

        doReset();

        // Scenario 1: three-cycle run stretched to five, one gap cycle.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(s1_in[i] != 0, 1'b0);
            checkLiteral($sformatf("s1.out@%0d", i + 1), out_a, ma.hi, s1_out[i]);
            checkLiteral($sformatf("s1.busy@%0d", i + 1), busy_a, ma.hi || (ma.g > 0), s1_busy[i]);
            checkLiteral($sformatf("s1.run_cnt@%0d", i + 1), run_cnt_a, ma.rc, s1_rc[i]);
        end

        // Scenario 2: single-cycle strobe.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(s2_in[i] != 0, 1'b0);
            checkLiteral($sformatf("s2.out@%0d", i + 1), out_a, ma.hi, s2_out[i]);
        end
        checkLiteral("s2.run_cnt", run_cnt_a, ma.rc, 2);

        // Scenario 3: a 1 arriving during the extension.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(s3_in[i] != 0, 1'b0);
            checkLiteral($sformatf("s3.out@%0d", i + 1), out_a, ma.hi, s3_out[i]);
        end
        checkLiteral("s3.run_cnt", run_cnt_a, ma.rc, 3);

        // Scenario 4: a 1 sampled in the gap is dropped; the next one starts a new expansion.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(s4_in[i] != 0, 1'b0);
            if (i == 6) begin
                checkLiteral("s4.out@7", out_a, ma.hi, 0);
                checkLiteral("s4.busy@7", busy_a, ma.hi || (ma.g > 0), 0);
                checkLiteral("s4.run_cnt@7", run_cnt_a, ma.rc, 4);
            end
            if (i == 7) checkLiteral("s4.out@8", out_a, ma.hi, 1);
        end
        checkLiteral("s4.run_cnt", run_cnt_a, ma.rc, 5);

        // Scenario 5: asynchronous reset in the middle of the extension.
        for (int i = 0; i < 4; i++) applyStimulus(s1_in[i] != 0, 1'b0);
        checkLiteral("s5.out_before", out_a, ma.hi, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("s5.out_async", out_a, 0);
        checkOutput("s5.busy_async", busy_a, 0);
        checkOutput("s5.run_cnt_async", run_cnt_a, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkLiteral($sformatf("s5.out_after@%0d", i + 1), out_a, ma.hi, 0);
            checkLiteral($sformatf("s5.busy_after@%0d", i + 1), busy_a, ma.hi || (ma.g > 0), 0);
        end
        checkLiteral("s5.run_cnt_after", run_cnt_a, ma.rc, 0);

        // Scenario 6: EXT=0, GAP=0, CW=4 instance; sixteen strobes wrap the counter.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkLiteral($sformatf("s6.out_hi#%0d", i), out_b, mb.hi, 1);
            applyStimulus(1'b0, 1'b0);
            checkLiteral($sformatf("s6.out_lo#%0d", i), out_b, mb.hi, 0);
            checkLiteral($sformatf("s6.run_cnt#%0d", i), run_cnt_b, mb.rc, (i + 1) % 16);
        end

        // Random phase with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
